// File: rtl/axi_write_arbiter.sv
// Round-robin arbiter sharing one AXI write slave (AW/W/B) among NUM_M masters, one burst in flight.
// Optional B-wait timeout with SLVERR response: define AXI_WARB_TIMEOUT_EN.

`ifndef ID_BITS
`define ID_BITS 4
`endif
`ifndef RESP_SLVERR
`define RESP_SLVERR 2'b10
`endif

module axi_write_arbiter #(
    parameter int NUM_M  = 2,
    parameter int ID_W   = `ID_BITS,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef AXI_WARB_TIMEOUT_EN
    ,
    parameter int TO_CYCLES = 256
`endif
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_M-1:0][ID_W-1:0]     m_awid,
    input  logic [NUM_M-1:0][ADDR_W-1:0]   m_awaddr,
    input  logic [NUM_M-1:0][7:0]          m_awlen,
    input  logic [NUM_M-1:0][2:0]          m_awsize,
    input  logic [NUM_M-1:0][1:0]          m_awburst,
    input  logic [NUM_M-1:0]               m_awvalid,
    output logic [NUM_M-1:0]               m_awready,
    input  logic [NUM_M-1:0][DATA_W-1:0]   m_wdata,
    input  logic [NUM_M-1:0][DATA_W/8-1:0] m_wstrb,
    input  logic [NUM_M-1:0]               m_wlast,
    input  logic [NUM_M-1:0]               m_wvalid,
    output logic [NUM_M-1:0]               m_wready,
    output logic [ID_W-1:0]                m_bid,
    output logic [1:0]                     m_bresp,
    output logic [NUM_M-1:0]               m_bvalid,
    input  logic [NUM_M-1:0]               m_bready,
    output logic [ID_W-1:0]                s_awid,
    output logic [ADDR_W-1:0]              s_awaddr,
    output logic [7:0]                     s_awlen,
    output logic [2:0]                     s_awsize,
    output logic [1:0]                     s_awburst,
    output logic                           s_awvalid,
    input  logic                           s_awready,
    output logic [DATA_W-1:0]              s_wdata,
    output logic [DATA_W/8-1:0]            s_wstrb,
    output logic                           s_wlast,
    output logic                           s_wvalid,
    input  logic                           s_wready,
    input  logic [ID_W-1:0]                s_bid,
    input  logic [1:0]                     s_bresp,
    input  logic                           s_bvalid,
    output logic                           s_bready,
    output logic [$clog2(NUM_M)-1:0]       o_grant,
    output logic                           o_busy,
    output logic                           o_timeout
);

    localparam int MW = $clog2(NUM_M);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
`ifdef AXI_WARB_TIMEOUT_EN
        ST_RESP,
        ST_RERR
`else
        ST_RESP
`endif
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [MW-1:0]   r_grant, r_rr_ptr, w_pick, w_grant_inc;
    logic            w_req_any, w_aw_hs, w_w_last_hs, w_b_hs, w_burst_done, w_stray;

    function automatic logic [MW-1:0] rr_idx(input logic [MW-1:0] base, input int off);
        return MW'((int'(base) + off) % NUM_M);
    endfunction

    // Scan downward so the last hit is the requester closest to r_rr_ptr.
    always_comb begin
        w_pick = r_rr_ptr;
        for (int i = NUM_M - 1; i >= 0; i--) begin
            if (m_awvalid[rr_idx(r_rr_ptr, i)]) w_pick = rr_idx(r_rr_ptr, i);
        end
    end

    assign w_req_any   = |m_awvalid;
    assign w_grant_inc = (r_grant == MW'(NUM_M - 1)) ? '0 : r_grant + MW'(1);
    assign w_aw_hs     = (r_state == ST_ADDR) && m_awvalid[r_grant] && s_awready;
    assign w_w_last_hs = (r_state == ST_DATA) && m_wvalid[r_grant] && s_wready && m_wlast[r_grant];
    assign w_b_hs      = (r_state == ST_RESP) && s_bvalid && m_bready[r_grant];

`ifdef AXI_WARB_TIMEOUT_EN
    logic [15:0]     r_to_cnt;
    logic            r_timeout, r_stray, w_to_hit;
    logic [ID_W-1:0] r_awid;

    assign w_to_hit     = (r_state == ST_RESP) && !s_bvalid && (r_to_cnt == 16'(TO_CYCLES - 1));
    assign w_burst_done = w_b_hs || ((r_state == ST_RERR) && m_bready[r_grant]);
    assign w_stray      = r_stray;
    assign o_timeout    = r_timeout;

    // After a timeout the slave still owes one B beat; it is swallowed before new grants.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
            r_stray   <= 1'b0;
            r_awid    <= '0;
        end else begin
            if (w_w_last_hs)
                r_to_cnt <= '0;
            else if (r_state == ST_RESP && !s_bvalid)
                r_to_cnt <= r_to_cnt + 16'd1;
            if (w_aw_hs) r_awid <= m_awid[r_grant];
            if (w_to_hit) begin
                r_timeout <= 1'b1;
                r_stray   <= 1'b1;
            end else if (r_stray && s_bvalid) begin
                r_stray <= 1'b0;
            end
        end
    end
`else
    assign w_burst_done = w_b_hs;
    assign w_stray      = 1'b0;
    assign o_timeout    = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_req_any && !w_stray) r_grant <= w_pick;
            if (w_burst_done) r_rr_ptr <= w_grant_inc;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        m_awready   = '0;
        m_wready    = '0;
        m_bvalid    = '0;
        s_awvalid   = 1'b0;
        s_wvalid    = 1'b0;
        s_bready    = w_stray;
        m_bid       = s_bid;
        m_bresp     = s_bresp;
        case (r_state)
            ST_IDLE: begin
                if (w_req_any && !w_stray) w_state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                s_awvalid          = m_awvalid[r_grant];
                m_awready[r_grant] = s_awready;
                if (w_aw_hs) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                s_wvalid          = m_wvalid[r_grant];
                m_wready[r_grant] = s_wready;
                if (w_w_last_hs) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                m_bvalid[r_grant] = s_bvalid;
                s_bready          = m_bready[r_grant];
                if (w_b_hs) w_state_nxt = ST_IDLE;
`ifdef AXI_WARB_TIMEOUT_EN
                else if (w_to_hit) w_state_nxt = ST_RERR;
`endif
            end
`ifdef AXI_WARB_TIMEOUT_EN
            ST_RERR: begin
                m_bvalid[r_grant] = 1'b1;
                m_bresp           = `RESP_SLVERR;
                m_bid             = r_awid;
                if (m_bready[r_grant]) w_state_nxt = ST_IDLE;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign s_awid    = m_awid[r_grant];
    assign s_awaddr  = m_awaddr[r_grant];
    assign s_awlen   = m_awlen[r_grant];
    assign s_awsize  = m_awsize[r_grant];
    assign s_awburst = m_awburst[r_grant];
    assign s_wdata   = m_wdata[r_grant];
    assign s_wstrb   = m_wstrb[r_grant];
    assign s_wlast   = m_wlast[r_grant];
    assign o_grant   = r_grant;
    assign o_busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Scoreboard bench for axi_write_arbiter with three masters and a behavioural slave.
// Expected AW/W/B traffic is queued by the stimulus; negedge monitors pop and compare.

module tb_axi_write_arbiter;

    localparam int NM       = 3;
    localparam int TO       = 16;
    localparam int WAIT_MAX = 500;

    logic clk_i = 1'b0;
    logic rst_i;
    logic [NM-1:0][3:0]  m_awid;
    logic [NM-1:0][31:0] m_awaddr;
    logic [NM-1:0][7:0]  m_awlen;
    logic [NM-1:0][2:0]  m_awsize;
    logic [NM-1:0][1:0]  m_awburst;
    logic [NM-1:0]       m_awvalid, m_awready;
    logic [NM-1:0][31:0] m_wdata;
    logic [NM-1:0][3:0]  m_wstrb;
    logic [NM-1:0]       m_wlast, m_wvalid, m_wready;
    logic [3:0]          m_bid;
    logic [1:0]          m_bresp;
    logic [NM-1:0]       m_bvalid, m_bready;
    logic [3:0]          s_awid;
    logic [31:0]         s_awaddr;
    logic [7:0]          s_awlen;
    logic [2:0]          s_awsize;
    logic [1:0]          s_awburst;
    logic                s_awvalid, s_awready;
    logic [31:0]         s_wdata;
    logic [3:0]          s_wstrb;
    logic                s_wlast, s_wvalid, s_wready;
    logic [3:0]          s_bid;
    logic [1:0]          s_bresp;
    logic                s_bvalid, s_bready;
    logic [1:0]          o_grant;
    logic                o_busy, o_timeout;

    axi_write_arbiter #(
        .NUM_M(NM), .ID_W(4), .ADDR_W(32), .DATA_W(32)
`ifdef AXI_WARB_TIMEOUT_EN
        , .TO_CYCLES(TO)
`endif
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
        .m_wready(m_wready), .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
        .m_bready(m_bready),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
        .s_wready(s_wready), .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
        .s_bready(s_bready),
        .o_grant(o_grant), .o_busy(o_busy), .o_timeout(o_timeout)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct { int m; logic [31:0] addr; logic [3:0] id; logic [7:0] len; } aw_t;
    typedef struct { logic [31:0] data; logic last; } w_t;
    typedef struct { int m; logic [3:0] id; logic [1:0] resp; } b_t;

    aw_t aw_q[$];
    w_t  w_q[$];
    b_t  b_q[$];
    int  aw_cyc[$];
    int  sb_cyc[$];

    int n_vec = 0;
    int n_err = 0;
    int n_exp = 0;
    int n_b   = 0;

    // slave knobs
    int aw_stall = 0;
    bit w_rand   = 0;
    int b_delay  = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait expired, got no handshake required one (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] wdat(input int m, input logic [31:0] addr, input int b);
        return 32'hA000_0000 | (32'(m) << 24) | ({16'h0, addr[15:0]} << 8) | 32'(b);
    endfunction

    task automatic expect_burst(input int m, input logic [31:0] addr, input logic [3:0] id,
                                input int len, input logic [1:0] resp);
        aw_t a;
        w_t  w;
        b_t  b;
        a.m = m; a.addr = addr; a.id = id; a.len = 8'(len);
        aw_q.push_back(a);
        for (int i = 0; i <= len; i++) begin
            w.data = wdat(m, addr, i);
            w.last = (i == len);
            w_q.push_back(w);
        end
        b.m = m; b.id = id; b.resp = resp;
        b_q.push_back(b);
        n_exp++;
    endtask

    task automatic master_burst(input int m, input logic [31:0] addr, input logic [3:0] id,
                                input int len, input bit early_w, input int b_stall);
        int n;
        @(posedge clk_i); #1;
        m_awid[m] = id; m_awaddr[m] = addr; m_awlen[m] = 8'(len);
        m_awsize[m] = 3'd2; m_awburst[m] = 2'b01; m_awvalid[m] = 1'b1;
        if (early_w) begin
            m_wdata[m] = wdat(m, addr, 0); m_wstrb[m] = 4'hF;
            m_wlast[m] = (len == 0); m_wvalid[m] = 1'b1;
        end
        for (n = 0; n < WAIT_MAX; n++) begin
            @(negedge clk_i);
            if (m_awready[m]) break;
        end
        if (n == WAIT_MAX) begin wait_fail("aw_wait"); m_awvalid[m] = 1'b0; return; end
        @(posedge clk_i); #1;
        m_awvalid[m] = 1'b0;
        for (int i = 0; i <= len; i++) begin
            m_wdata[m] = wdat(m, addr, i); m_wstrb[m] = 4'hF;
            m_wlast[m] = (i == len); m_wvalid[m] = 1'b1;
            for (n = 0; n < WAIT_MAX; n++) begin
                @(negedge clk_i);
                if (m_wready[m]) break;
            end
            if (n == WAIT_MAX) begin wait_fail("w_wait"); m_wvalid[m] = 1'b0; return; end
            @(posedge clk_i); #1;
        end
        m_wvalid[m] = 1'b0; m_wlast[m] = 1'b0;
        for (n = 0; n < WAIT_MAX; n++) begin
            @(negedge clk_i);
            if (m_bvalid[m]) break;
        end
        if (n == WAIT_MAX) begin wait_fail("b_wait"); return; end
        repeat (b_stall) @(negedge clk_i);
        @(posedge clk_i); #1;
        m_bready[m] = 1'b1;
        for (n = 0; n < WAIT_MAX; n++) begin
            @(negedge clk_i);
            if (m_bvalid[m] && m_bready[m]) break;
        end
        if (n == WAIT_MAX) wait_fail("b_hs_wait");
        @(posedge clk_i); #1;
        m_bready[m] = 1'b0;
    endtask

    task automatic master_seq(input int m);
        for (int k = 0; k < 3; k++)
            master_burst(m, 32'h1000 + 32'(m * 256 + k * 16), 4'(m * 4 + k), k, 1'b0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    // Behavioural slave: one burst at a time, configurable backpressure and B delay.
    initial begin
        logic [3:0] id_c;
        bit         last_seen;
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bid = '0; s_bresp = 2'b00;
        forever begin
            do @(negedge clk_i); while (!(s_awvalid && !rst_i));
            repeat (aw_stall) @(negedge clk_i);
            @(posedge clk_i); #1 s_awready = 1'b1;
            @(negedge clk_i); id_c = s_awid;
            @(posedge clk_i); #1 s_awready = 1'b0;
            last_seen = 1'b0;
            while (!last_seen) begin
                s_wready = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                @(negedge clk_i);
                if (s_wvalid && s_wready && s_wlast) last_seen = 1'b1;
                @(posedge clk_i); #1;
            end
            s_wready = 1'b0;
            repeat (b_delay) @(posedge clk_i);
            #1;
            s_bvalid = 1'b1; s_bid = id_c; s_bresp = 2'b00;
            do @(negedge clk_i); while (!s_bready);
            sb_cyc.push_back(cyc);
            @(posedge clk_i); #1 s_bvalid = 1'b0;
        end
    end

    // Monitor / scoreboard.
    int          outstanding = 0;
    bit          aw_fwd = 0, aw_stalled = 0, b_stalled = 0, bv_prev = 0;
    logic [31:0] prev_awaddr;
    logic [NM-1:0] prev_bvalid;
    logic [3:0]  prev_bid;
    int          last_w_cyc = 0, bv_rise_cyc = 0;

    initial begin
        aw_t ea;
        w_t  ew;
        b_t  eb;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                outstanding = 0; aw_fwd = 0; aw_stalled = 0; b_stalled = 0; bv_prev = 0;
            end else begin
                if (aw_stalled) begin
                    check("aw_valid_held", s_awvalid, 1);
                    check("aw_addr_held", s_awaddr, prev_awaddr);
                end
                if (s_awvalid && s_awready) begin
                    check("aw_one_outstanding", outstanding, 0);
                    check("aw_expected", aw_q.size() != 0, 1);
                    if (aw_q.size() != 0) begin
                        ea = aw_q.pop_front();
                        check("aw_grant", o_grant, ea.m);
                        check("aw_addr", s_awaddr, ea.addr);
                        check("aw_id", s_awid, ea.id);
                        check("aw_len", s_awlen, ea.len);
                        check("aw_size_burst", {s_awsize, s_awburst}, {3'd2, 2'b01});
                    end
                    outstanding++;
                    aw_fwd = 1;
                    aw_cyc.push_back(cyc);
                end
                aw_stalled  = s_awvalid && !s_awready;
                prev_awaddr = s_awaddr;

                if (s_wvalid) check("w_after_aw", aw_fwd, 1);
                if (s_wvalid && s_wready) begin
                    check("w_expected", w_q.size() != 0, 1);
                    if (w_q.size() != 0) begin
                        ew = w_q.pop_front();
                        check("w_data", s_wdata, ew.data);
                        check("w_last", s_wlast, ew.last);
                        check("w_strb", s_wstrb, 4'hF);
                    end
                    if (s_wlast) begin aw_fwd = 0; last_w_cyc = cyc; end
                end

                if (b_stalled) begin
                    check("b_valid_held", m_bvalid, prev_bvalid);
                    check("b_id_held", m_bid, prev_bid);
                end
                if ((|m_bvalid) && !bv_prev) bv_rise_cyc = cyc;
                if (|(m_bvalid & m_bready)) begin
                    check("b_expected", b_q.size() != 0, 1);
                    if (b_q.size() != 0) begin
                        eb = b_q.pop_front();
                        check("b_onehot", m_bvalid, NM'(1) << eb.m);
                        check("b_id", m_bid, eb.id);
                        check("b_resp", m_bresp, eb.resp);
                    end
                    outstanding--;
                    n_b++;
                end
                b_stalled   = (|m_bvalid) && !(|(m_bvalid & m_bready));
                prev_bvalid = m_bvalid;
                prev_bid    = m_bid;
                bv_prev     = |m_bvalid;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_awid = '0; m_awaddr = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0;
        m_wdata = '0; m_wstrb = '0; m_wlast = '0; m_wvalid = '0; m_bready = '0;
        rst_i = 1'b1;
        m_awvalid = '1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_grant", o_grant, 0);
        check("rst_busy", o_busy, 0);
        check("rst_ready", {m_awready, m_wready}, 0);
        check("rst_bvalid", m_bvalid, 0);
        check("rst_s_valid", {s_awvalid, s_wvalid, s_bready}, 0);
        check("rst_timeout", o_timeout, 0);
        @(posedge clk_i); #1;
        m_awvalid = '0;
        rst_i = 1'b0;

        // single master 0, 4 beats
        expect_burst(0, 32'h100, 4'h5, 3, 2'b00);
        master_burst(0, 32'h100, 4'h5, 3, 1'b0, 0);
        repeat (3) @(negedge clk_i);
        check("t1_grant", o_grant, 0);
        check("t1_idle", o_busy, 0);

        // rr_ptr=1 now: master 2 beats master 0
        expect_burst(2, 32'h200, 4'h2, 1, 2'b00);
        expect_burst(0, 32'h140, 4'h6, 0, 2'b00);
        fork
            master_burst(0, 32'h140, 4'h6, 0, 1'b0, 0);
            master_burst(2, 32'h200, 4'h2, 1, 1'b0, 0);
        join

        // after reset: 0 then 1, master 1 presents W early
        do_reset();
        expect_burst(0, 32'h300, 4'h1, 2, 2'b00);
        expect_burst(1, 32'h400, 4'h9, 1, 2'b00);
        fork
            master_burst(0, 32'h300, 4'h1, 2, 1'b0, 0);
            master_burst(1, 32'h400, 4'h9, 1, 1'b1, 0);
        join

        // backpressure on every channel
        aw_stall = 5; w_rand = 1;
        expect_burst(2, 32'h500, 4'h3, 3, 2'b00);
        master_burst(2, 32'h500, 4'h3, 3, 1'b0, 3);
        aw_stall = 0; w_rand = 0;

        // fairness: grant order 0,1,2 x3
        do_reset();
        for (int k = 0; k < 3; k++)
            for (int m = 0; m < NM; m++)
                expect_burst(m, 32'h1000 + 32'(m * 256 + k * 16), 4'(m * 4 + k), k, 2'b00);
        fork
            master_seq(0);
            master_seq(1);
            master_seq(2);
        join

`ifdef AXI_WARB_TIMEOUT_EN
        // slave answers long after the timeout; its late B must be absorbed
        b_delay = 40;
        sb_cyc.delete();
        aw_cyc.delete();
        expect_burst(1, 32'h600, 4'hA, 1, 2'b10);
        master_burst(1, 32'h600, 4'hA, 1, 1'b0, 0);
        check("to_flag", o_timeout, 1);
        check("to_latency", (bv_rise_cyc - last_w_cyc >= TO) && (bv_rise_cyc - last_w_cyc <= TO + 2), 1);
        b_delay = 1;
        expect_burst(0, 32'h700, 4'hB, 0, 2'b00);
        master_burst(0, 32'h700, 4'hB, 0, 1'b0, 0);
        check("to_flag_sticky", o_timeout, 1);
        check("to_late_b_seen", sb_cyc.size() >= 1 && aw_cyc.size() >= 2, 1);
        if (sb_cyc.size() >= 1 && aw_cyc.size() >= 2)
            check("to_grant_after_absorb", aw_cyc[1] > sb_cyc[0], 1);
`endif

        repeat (20) @(negedge clk_i);
        check("aw_q_empty", aw_q.size(), 0);
        check("w_q_empty", w_q.size(), 0);
        check("b_q_empty", b_q.size(), 0);
        check("b_count", n_b, n_exp);
        check("end_idle", o_busy, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
